jam_cost_table: RTL and testbench

Upstream cost-matrix store for the job-assignment engine. Accepts an 8×8 worker/job cost matrix as a row-major valid/ready stream. Serves same-cycle combinational `Cost` lookups for the engine's `W`/`J` request. Holds the engine in reset until the matrix is complete and recycles for the next matrix when the engine reports `Valid`. Also accumulates the sum of per-worker row minima as a lower bound for result checking.

---
 rtl/jam_cost_table_pkg.sv | 21 ++
 rtl/jam_cost_table_cost_row_min.sv | 46 ++++
 rtl/jam_cost_table.sv | 115 +++++++++++
 tb/tb_jam_cost_table.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jam_cost_table_pkg.sv
// Shared sizes, FSM encoding and helpers for the job-assignment cost-matrix store.
package jam_cost_table_pkg;

    localparam int N  = 8;
    localparam int CW = 7;
    localparam int BW = 10;
    localparam int AW = 6;

    localparam logic [AW-1:0] LAST_BEAT = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

    function automatic logic [CW-1:0] cost_min(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_cost_table_cost_row_min.sv
// Running per-row minimum of the load stream and sum of completed row minima.
module cost_row_min
    import jam_cost_table_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic          acc,
    input  logic [CW-1:0] in_cost,
    input  logic [2:0]    col,
    output logic [BW-1:0] lower_bound
);

    logic [CW-1:0] row_min_r;
    logic [BW-1:0] lower_bound_r;
    logic [CW-1:0] min_s;

    // minimum including the beat currently being accepted
    always_comb begin
        min_s = cost_min(row_min_r, in_cost);
    end

    // row-minimum tracking and accumulation on the last job of each row
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_min_r     <= {CW{1'b0}};
            lower_bound_r <= {BW{1'b0}};
        end else if (clr) begin
            row_min_r     <= {CW{1'b0}};
            lower_bound_r <= {BW{1'b0}};
        end else if (acc) begin
            row_min_r <= (col == 3'd0) ? in_cost : min_s;
            if (col == 3'd7) begin
                lower_bound_r <= lower_bound_r + {{(BW-CW){1'b0}}, min_s};
            end else begin
                lower_bound_r <= lower_bound_r;
            end
        end else begin
            row_min_r     <= row_min_r;
            lower_bound_r <= lower_bound_r;
        end
    end

    assign lower_bound = lower_bound_r;

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 cost-matrix store: streams a matrix in, serves same-cycle lookups and
// holds the assignment engine in reset until a complete matrix is present.
module jam_cost_table
    import jam_cost_table_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_cost,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    input  logic          jam_valid,
    output logic          JAM_RST,
    output logic          table_ready,
    output logic [BW-1:0] lower_bound
);

    state_t        state_r;
    logic [AW-1:0] ld_cnt_r;
    logic          jam_rst_r;
    logic          table_ready_r;
    logic [CW-1:0] mem_r [0:63];
    logic          accept_s;
    logic          clr_s;
    logic [CW-1:0] cost_s;

    // handshake and the cycles on which the FSM is about to enter LOAD
    always_comb begin
        accept_s = in_valid && (state_r == LOAD);
        clr_s    = (state_r == IDLE) || ((state_r == SERVE) && jam_valid);
    end

    // control FSM with registered engine reset and ready flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= IDLE;
            ld_cnt_r      <= {AW{1'b0}};
            jam_rst_r     <= 1'b1;
            table_ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r       <= LOAD;
                    ld_cnt_r      <= {AW{1'b0}};
                    jam_rst_r     <= 1'b1;
                    table_ready_r <= 1'b0;
                end
                LOAD: begin
                    if (accept_s) begin
                        ld_cnt_r <= ld_cnt_r + 6'd1;
                        if (ld_cnt_r == LAST_BEAT) begin
                            state_r       <= SERVE;
                            jam_rst_r     <= 1'b0;
                            table_ready_r <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        ld_cnt_r <= ld_cnt_r;
                    end
                end
                SERVE: begin
                    if (jam_valid) begin
                        state_r       <= LOAD;
                        ld_cnt_r      <= {AW{1'b0}};
                        jam_rst_r     <= 1'b1;
                        table_ready_r <= 1'b0;
                    end else begin
                        state_r <= SERVE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    ld_cnt_r      <= {AW{1'b0}};
                    jam_rst_r     <= 1'b1;
                    table_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // register file deliberately unreset; reads are gated by table_ready
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            mem_r[ld_cnt_r] <= in_cost;
        end
    end

    // zero-latency lookup for the engine
    always_comb begin
        if (table_ready_r) begin
            cost_s = mem_r[{W, J}];
        end else begin
            cost_s = {CW{1'b0}};
        end
    end

    cost_row_min u_row_min (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clr         (clr_s),
        .acc         (accept_s),
        .in_cost     (in_cost),
        .col         (ld_cnt_r[2:0]),
        .lower_bound (lower_bound)
    );

    assign in_ready    = (state_r == LOAD);
    assign Cost        = cost_s;
    assign JAM_RST     = jam_rst_r;
    assign table_ready = table_ready_r;

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table: vector table lookups plus load/recycle/reset sequences.
module tb_jam_cost_table;

    logic       CLK;
    logic       RST_N;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_cost;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       jam_valid;
    logic       JAM_RST;
    logic       table_ready;
    logic [9:0] lower_bound;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] exp_cost;
    } vec_t;

    vec_t       vecs [6];
    logic [6:0] mat  [64];

    jam_cost_table dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cost     (in_cost),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .jam_valid   (jam_valid),
        .JAM_RST     (JAM_RST),
        .table_ready (table_ready),
        .lower_bound (lower_bound)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_jam_rst"}, int'(JAM_RST), 1);
        chk({tag, "_table_ready"}, int'(table_ready), 0);
        chk({tag, "_lower_bound"}, int'(lower_bound), 0);
        chk({tag, "_cost"}, int'(Cost), 0);
    endtask

    // streams mat[0 .. stop_at-1]; optional gaps and a jam_valid pulse at beat jv_beat
    task automatic load(input bit gaps, input int jv_beat, input int stop_at);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        W   = 3'd3;
        J   = 3'd5;
        while (k < stop_at && cyc < 3000) begin
            @(negedge CLK);
            chk("load_jam_rst", int'(JAM_RST), 1);
            chk("load_cost_gated", int'(Cost), 0);
            chk("load_not_ready", int'(table_ready), 0);
            in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_cost   = mat[k];
            jam_valid = (k == jv_beat);
            if (in_valid && in_ready) k++;
            cyc++;
        end
        if (cyc >= 3000) chk("load_timeout_beats", k, stop_at);
        @(negedge CLK);
        in_valid  = 1'b0;
        jam_valid = 1'b0;
        if (stop_at == 64) begin
            chk("serve_table_ready", int'(table_ready), 1);
            chk("serve_jam_rst", int'(JAM_RST), 0);
            chk("serve_in_ready", int'(in_ready), 0);
        end
    endtask

    task automatic recycle();
        @(negedge CLK);
        jam_valid = 1'b1;
        @(negedge CLK);
        jam_valid = 1'b0;
        chk("recycle_jam_rst", int'(JAM_RST), 1);
        chk("recycle_table_ready", int'(table_ready), 0);
        chk("recycle_cost", int'(Cost), 0);
        chk("recycle_in_ready", int'(in_ready), 1);
        chk("recycle_lower_bound", int'(lower_bound), 0);
    endtask

    task automatic apply_vecs(input string tag);
        for (int i = 0; i < 6; i++) begin
            W = vecs[i].w;
            J = vecs[i].j;
            #1;
            chk({tag, "_cost"}, int'(Cost), int'(vecs[i].exp_cost));
        end
    endtask

    task automatic check_cost(input string name, input logic [2:0] w, input logic [2:0] j, input int exp);
        W = w;
        J = j;
        #1;
        chk(name, int'(Cost), exp);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 64; k++) mat[k] = 7'((k % 8) + 1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        // lookups into the ramp matrix mem[k] = k%8 + 1
        vecs[0] = '{w: 3'd3, j: 3'd5, exp_cost: 7'd6};
        vecs[1] = '{w: 3'd0, j: 3'd0, exp_cost: 7'd1};
        vecs[2] = '{w: 3'd7, j: 3'd7, exp_cost: 7'd8};
        vecs[3] = '{w: 3'd5, j: 3'd2, exp_cost: 7'd3};
        vecs[4] = '{w: 3'd1, j: 3'd6, exp_cost: 7'd7};
        vecs[5] = '{w: 3'd6, j: 3'd0, exp_cost: 7'd1};

        RST_N     = 1'b0;
        in_valid  = 1'b1;
        in_cost   = 7'd0;
        W         = 3'd3;
        J         = 3'd5;
        jam_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST_N    = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("first_edge_in_ready", int'(in_ready), 1);

        // plain load of the ramp matrix
        set_ramp();
        load(1'b0, -1, 64);
        chk("ramp_lower_bound", int'(lower_bound), 8);
        apply_vecs("ramp");

        // in_valid during SERVE is ignored
        in_valid = 1'b1;
        in_cost  = 7'd99;
        repeat (3) @(negedge CLK);
        in_valid = 1'b0;
        chk("ign_inv_table_ready", int'(table_ready), 1);
        chk("ign_inv_jam_rst", int'(JAM_RST), 0);
        chk("ign_inv_lower_bound", int'(lower_bound), 8);
        check_cost("ign_inv_cost_00", 3'd0, 3'd0, 1);
        check_cost("ign_inv_cost_35", 3'd3, 3'd5, 6);

        // same matrix under back-pressure
        recycle();
        load(1'b1, -1, 64);
        chk("bp_lower_bound", int'(lower_bound), 8);
        apply_vecs("bp");

        // one cheap cell per row on the diagonal
        recycle();
        for (int k = 0; k < 64; k++) mat[k] = ((k / 8) == (k % 8)) ? 7'((k / 8) + 10) : 7'd127;
        load(1'b0, -1, 64);
        chk("diag_lower_bound", int'(lower_bound), 108);
        check_cost("diag_cost_22", 3'd2, 3'd2, 12);
        check_cost("diag_cost_23", 3'd2, 3'd3, 127);

        // max costs must not wrap the bound
        recycle();
        for (int k = 0; k < 64; k++) mat[k] = 7'd127;
        load(1'b0, -1, 64);
        chk("max_lower_bound", int'(lower_bound), 1016);

        // all-5 matrix after recycle
        recycle();
        for (int k = 0; k < 64; k++) mat[k] = 7'd5;
        load(1'b0, -1, 64);
        chk("five_lower_bound", int'(lower_bound), 40);
        check_cost("five_cost_74", 3'd7, 3'd4, 5);

        // jam_valid during LOAD is ignored; row minimum sits at job 7 = 13 + 8w
        recycle();
        for (int k = 0; k < 64; k++) mat[k] = 7'(20 + 8 * (k / 8) - (k % 8));
        load(1'b0, 10, 64);
        chk("jv_load_lower_bound", int'(lower_bound), 328);
        check_cost("jv_load_cost_41", 3'd4, 3'd1, 51);
        check_cost("jv_load_cost_12", 3'd1, 3'd2, 26);

        // reset after 30 beats, then a full reload
        recycle();
        set_ramp();
        for (int k = 0; k < 64; k++) mat[k] = 7'd100;
        load(1'b0, -1, 30);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        check_reset_outputs("midrst_hold");
        RST_N = 1'b1;
        set_ramp();
        load(1'b0, -1, 64);
        chk("midrst_lower_bound", int'(lower_bound), 8);
        apply_vecs("midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
